// File: rtl/mux_host_ctrl.sv
// -----------------------------------------------------------------------------
// mux_host_ctrl
//   Host-side initiator for the console-mux UART command protocol. One command
//   is accepted per valid/ready handshake. Its opcode and payload bytes are sent
//   MSB first through an external uart_tx. Response bytes from an external
//   uart_rx are then shifted into a 32-bit result word. Completion is reported
//   with a one-cycle resp_valid pulse. resp_err flags an invalid opcode or a
//   stalled transfer.
//
// Ports
//   clk, rst               system clock; asynchronous active-high reset
//   cmd_valid/cmd_ready    command handshake (ready only while idle)
//   cmd_op[2:0]            1=READ_MASK 2=READ_PINMAP 3=WRITE_MASK 4=WRITE_PINMAP
//   cmd_wdata[31:0]        write payload (mask uses [15:0])
//   resp_valid             one-cycle completion pulse
//   resp_data[31:0]        read result, zero-extended; held until next accept
//   resp_err               qualifies resp_valid: invalid opcode or timeout
//   tx_data[7:0], tx_start byte and start pulse to uart_tx
//   tx_done                uart_tx idle level (high = idle)
//   rx_ready, rx_data[7:0] uart_rx byte strobe (rising edge) and byte
// -----------------------------------------------------------------------------
module mux_host_ctrl #(
   parameter int CLOCK_PER_BIT = 16,
   parameter int RESP_TIMEOUT  = 4096
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic [2:0]  cmd_op,
   input  logic [31:0] cmd_wdata,
   output logic        resp_valid,
   output logic [31:0] resp_data,
   output logic        resp_err,
   output logic [7:0]  tx_data,
   output logic        tx_start,
   input  logic        tx_done,
   input  logic        rx_ready,
   input  logic [7:0]  rx_data
);

   // The cycle counter is wide enough for the timeout limit and for at least
   // one UART frame plus margin, so small timeout settings still size sensibly.
   localparam int FRAME_SPAN = CLOCK_PER_BIT * 12;
   localparam int CNT_MAX    = (RESP_TIMEOUT > FRAME_SPAN) ? RESP_TIMEOUT : FRAME_SPAN;
   localparam int CNT_W      = $clog2(CNT_MAX + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RESP_TIMEOUT - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_TX_START,
      S_TX_WAIT_BUSY,
      S_TX_WAIT_IDLE,
      S_RECV,
      S_DONE
   } state_t;

   state_t           state_q,      state_d;
   logic [39:0]      tx_sh_q,      tx_sh_d;
   logic [2:0]       tx_left_q,    tx_left_d;
   logic [2:0]       rx_left_q,    rx_left_d;
   logic [CNT_W-1:0] cnt_q,        cnt_d;
   logic             rx_prev_q,    rx_prev_d;
   logic             cmd_ready_q,  cmd_ready_d;
   logic             tx_start_q,   tx_start_d;
   logic [7:0]       tx_data_q,    tx_data_d;
   logic             resp_valid_q, resp_valid_d;
   logic [31:0]      resp_data_q,  resp_data_d;
   logic             resp_err_q,   resp_err_d;

   logic rx_edge;
   logic rx_taken;
   logic busy;

   assign rx_edge = rx_ready & ~rx_prev_q;

   always_comb begin
      state_d      = state_q;
      tx_sh_d      = tx_sh_q;
      tx_left_d    = tx_left_q;
      rx_left_d    = rx_left_q;
      cnt_d        = cnt_q + CNT_W'(1);
      rx_prev_d    = rx_ready;
      cmd_ready_d  = cmd_ready_q;
      tx_start_d   = 1'b0;
      tx_data_d    = tx_data_q;
      resp_valid_d = 1'b0;
      resp_data_d  = resp_data_q;
      resp_err_d   = resp_err_q;
      rx_taken     = 1'b0;
      busy         = (state_q != S_IDLE) && (state_q != S_DONE);

      case (state_q)
         S_IDLE: begin
            cnt_d       = '0;
            cmd_ready_d = 1'b1;
            if (cmd_valid && cmd_ready_q) begin
               resp_data_d = '0;
               resp_err_d  = 1'b0;
               // The byte plan is latched here; the shift register always
               // presents the next byte to send in its top eight bits.
               case (cmd_op)
                  3'd1: begin
                     tx_sh_d     = {8'h01, 32'h0};
                     tx_left_d   = 3'd1;
                     rx_left_d   = 3'd2;
                     state_d     = S_TX_START;
                     cmd_ready_d = 1'b0;
                  end
                  3'd2: begin
                     tx_sh_d     = {8'h02, 32'h0};
                     tx_left_d   = 3'd1;
                     rx_left_d   = 3'd4;
                     state_d     = S_TX_START;
                     cmd_ready_d = 1'b0;
                  end
                  3'd3: begin
                     tx_sh_d     = {8'h03, cmd_wdata[15:0], 16'h0};
                     tx_left_d   = 3'd3;
                     rx_left_d   = 3'd0;
                     state_d     = S_TX_START;
                     cmd_ready_d = 1'b0;
                  end
                  3'd4: begin
                     tx_sh_d     = {8'h04, cmd_wdata};
                     tx_left_d   = 3'd5;
                     rx_left_d   = 3'd0;
                     state_d     = S_TX_START;
                     cmd_ready_d = 1'b0;
                  end
                  default: begin
                     // Unknown opcode: report the error immediately and stay
                     // idle, so nothing reaches the UART.
                     resp_valid_d = 1'b1;
                     resp_err_d   = 1'b1;
                  end
               endcase
            end
         end

         S_TX_START: begin
            if (tx_done) begin
               tx_start_d = 1'b1;
               tx_data_d  = tx_sh_q[39:32];
               tx_sh_d    = {tx_sh_q[31:0], 8'h00};
               tx_left_d  = tx_left_q - 3'd1;
               state_d    = S_TX_WAIT_BUSY;
            end
         end

         S_TX_WAIT_BUSY: begin
            if (!tx_done) begin
               state_d = S_TX_WAIT_IDLE;
            end
         end

         S_TX_WAIT_IDLE: begin
            if (tx_done) begin
               if (tx_left_q != 3'd0) begin
                  state_d = S_TX_START;
               end else if (rx_left_q != 3'd0) begin
                  state_d = S_RECV;
               end else begin
                  state_d      = S_DONE;
                  resp_valid_d = 1'b1;
                  resp_err_d   = 1'b0;
               end
            end
         end

         S_RECV: begin
            if (rx_edge) begin
               rx_taken    = 1'b1;
               resp_data_d = {resp_data_q[23:0], rx_data};
               rx_left_d   = rx_left_q - 3'd1;
               cnt_d       = '0;
               if (rx_left_q == 3'd1) begin
                  state_d      = S_DONE;
                  resp_valid_d = 1'b1;
                  resp_err_d   = 1'b0;
               end
            end
         end

         S_DONE: begin
            cnt_d       = '0;
            cmd_ready_d = 1'b1;
            state_d     = S_IDLE;
         end

         default: begin
            cnt_d       = '0;
            cmd_ready_d = 1'b1;
            state_d     = S_IDLE;
         end
      endcase

      // Any progress restarts the timeout window. Without progress, the
      // counter running out ends the command with an error and keeps the
      // bytes already assembled.
      if (state_d != state_q) begin
         cnt_d = '0;
      end else if (busy && !rx_taken && (cnt_q == CNT_LAST)) begin
         state_d      = S_IDLE;
         cnt_d        = '0;
         cmd_ready_d  = 1'b1;
         tx_start_d   = 1'b0;
         resp_valid_d = 1'b1;
         resp_err_d   = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= S_IDLE;
         tx_sh_q      <= '0;
         tx_left_q    <= '0;
         rx_left_q    <= '0;
         cnt_q        <= '0;
         rx_prev_q    <= 1'b0;
         cmd_ready_q  <= 1'b1;
         tx_start_q   <= 1'b0;
         tx_data_q    <= 8'hFF;
         resp_valid_q <= 1'b0;
         resp_data_q  <= '0;
         resp_err_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         tx_sh_q      <= tx_sh_d;
         tx_left_q    <= tx_left_d;
         rx_left_q    <= rx_left_d;
         cnt_q        <= cnt_d;
         rx_prev_q    <= rx_prev_d;
         cmd_ready_q  <= cmd_ready_d;
         tx_start_q   <= tx_start_d;
         tx_data_q    <= tx_data_d;
         resp_valid_q <= resp_valid_d;
         resp_data_q  <= resp_data_d;
         resp_err_q   <= resp_err_d;
      end
   end

   assign cmd_ready  = cmd_ready_q;
   assign tx_start   = tx_start_q;
   assign tx_data    = tx_data_q;
   assign resp_valid = resp_valid_q;
   assign resp_data  = resp_data_q;
   assign resp_err   = resp_err_q;

endmodule

// File: tb/tb_mux_host_ctrl.sv
// -----------------------------------------------------------------------------
// tb_mux_host_ctrl
//   Directed bench for mux_host_ctrl. A small uart_tx stand-in logs every byte
//   started and holds tx_done low for a few cycles per byte. Response bytes are
//   driven directly from the stimulus sequence.
// -----------------------------------------------------------------------------
module tb_mux_host_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [2:0]  cmd_op;
   logic [31:0] cmd_wdata;
   logic        resp_valid;
   logic [31:0] resp_data;
   logic        resp_err;
   logic [7:0]  tx_data;
   logic        tx_start;
   logic        tx_done;
   logic        rx_ready;
   logic [7:0]  rx_data;

   int vectors     = 0;
   int miscompares = 0;

   mux_host_ctrl #(
      .CLOCK_PER_BIT(16),
      .RESP_TIMEOUT (64)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .cmd_op    (cmd_op),
      .cmd_wdata (cmd_wdata),
      .resp_valid(resp_valid),
      .resp_data (resp_data),
      .resp_err  (resp_err),
      .tx_data   (tx_data),
      .tx_start  (tx_start),
      .tx_done   (tx_done),
      .rx_ready  (rx_ready),
      .rx_data   (rx_data)
   );

   always #5 clk = ~clk;

   // uart_tx stand-in: logs each started byte, counts starts issued while busy.
   logic [7:0] tx_log [0:15];
   int         tx_n      = 0;
   int         start_bad = 0;
   int         busy_cnt  = 0;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         tx_done  <= 1'b1;
         busy_cnt <= 0;
      end else if (tx_start) begin
         if (!tx_done) start_bad <= start_bad + 1;
         if (tx_n < 16) tx_log[tx_n] <= tx_data;
         tx_n     <= tx_n + 1;
         tx_done  <= 1'b0;
         busy_cnt <= 6;
      end else if (busy_cnt > 0) begin
         busy_cnt <= busy_cnt - 1;
         if (busy_cnt == 1) tx_done <= 1'b1;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic accept(input logic [2:0] op, input logic [31:0] wdata);
      int n;
      n = 0;
      while (!cmd_ready && n < 200) begin
         tick();
         n++;
      end
      check("accept_ready", {31'd0, cmd_ready}, 32'd1);
      cmd_valid = 1'b1;
      cmd_op    = op;
      cmd_wdata = wdata;
      tick();
      // Scramble inputs after accept; the DUT must use its captured copy.
      cmd_valid = 1'b0;
      cmd_op    = 3'd7;
      cmd_wdata = 32'hDEADBEEF;
   endtask

   // Waits for the stand-in to have logged `target` bytes and gone idle, then
   // lets the DUT see tx_done and enter its receive state.
   task automatic wait_tx_idle(input string tag, input int target);
      int n;
      logic ok;
      n  = 0;
      ok = 1'b0;
      while (n < 300) begin
         if (tx_n == target && tx_done) begin
            ok = 1'b1;
            break;
         end
         tick();
         n++;
      end
      check(tag, {31'd0, ok}, 32'd1);
      tick();
      tick();
   endtask

   task automatic wait_resp(input string tag, input int limit, output int cycles);
      logic ok;
      ok     = 1'b0;
      cycles = 0;
      while (cycles < limit) begin
         tick();
         cycles++;
         if (resp_valid) begin
            ok = 1'b1;
            break;
         end
      end
      check(tag, {31'd0, ok}, 32'd1);
   endtask

   task automatic send_rx(input logic [7:0] b);
      rx_data  = b;
      rx_ready = 1'b1;
      tick();
      rx_ready = 1'b0;
      tick();
   endtask

   task automatic read_mask(input string tag);
      int base;
      base = tx_n;
      accept(3'd1, 32'h0);
      wait_tx_idle({tag, "_txidle"}, base + 1);
      send_rx(8'hAA);
      check({tag, "_novld_mid"}, {31'd0, resp_valid}, 32'd0);
      rx_data  = 8'h55;
      rx_ready = 1'b1;
      tick();
      check({tag, "_vld"},   {31'd0, resp_valid}, 32'd1);
      check({tag, "_data"},  resp_data, 32'h0000AA55);
      check({tag, "_err"},   {31'd0, resp_err}, 32'd0);
      check({tag, "_busy"},  {31'd0, cmd_ready}, 32'd0);
      rx_ready = 1'b0;
      tick();
      check({tag, "_pulse"}, {31'd0, resp_valid}, 32'd0);
      check({tag, "_ready"}, {31'd0, cmd_ready}, 32'd1);
      check({tag, "_txcnt"}, tx_n - base, 32'd1);
      check({tag, "_txb0"},  {24'd0, tx_log[base]}, 32'h01);
   endtask

   initial begin
      int base;
      int cyc;
      int rv_seen;

      rst       = 1'b1;
      cmd_valid = 1'b0;
      cmd_op    = 3'd0;
      cmd_wdata = 32'h0;
      rx_ready  = 1'b0;
      rx_data   = 8'h00;
      tick();
      tick();
      check("rst_ready",    {31'd0, cmd_ready},  32'd1);
      check("rst_txstart",  {31'd0, tx_start},   32'd0);
      check("rst_txdata",   {24'd0, tx_data},    32'hFF);
      check("rst_respvld",  {31'd0, resp_valid}, 32'd0);
      check("rst_respdata", resp_data,           32'd0);
      check("rst_resperr",  {31'd0, resp_err},   32'd0);
      rst = 1'b0;
      tick();

      // T1: READ_MASK returning AA, 55
      read_mask("t1");

      // T2: WRITE_PINMAP 12345678
      base = tx_n;
      accept(3'd4, 32'h12345678);
      wait_resp("t2_resp", 300, cyc);
      check("t2_data",   resp_data, 32'h0);
      check("t2_err",    {31'd0, resp_err}, 32'd0);
      check("t2_txcnt",  tx_n - base, 32'd5);
      check("t2_b0",     {24'd0, tx_log[base]},     32'h04);
      check("t2_b1",     {24'd0, tx_log[base + 1]}, 32'h12);
      check("t2_b2",     {24'd0, tx_log[base + 2]}, 32'h34);
      check("t2_b3",     {24'd0, tx_log[base + 3]}, 32'h56);
      check("t2_b4",     {24'd0, tx_log[base + 4]}, 32'h78);
      check("t2_nobusy_start", start_bad, 32'd0);
      tick();
      check("t2_pulse",  {31'd0, resp_valid}, 32'd0);
      tick();
      check("t2_ready",  {31'd0, cmd_ready}, 32'd1);

      // T3: invalid opcode 6
      base = tx_n;
      accept(3'd6, 32'hFFFFFFFF);
      check("t3_vld",     {31'd0, resp_valid}, 32'd1);
      check("t3_err",     {31'd0, resp_err}, 32'd1);
      check("t3_data",    resp_data, 32'h0);
      check("t3_nostart", {31'd0, tx_start}, 32'd0);
      tick();
      check("t3_pulse",   {31'd0, resp_valid}, 32'd0);
      check("t3_ready",   {31'd0, cmd_ready}, 32'd1);
      check("t3_notx",    tx_n - base, 32'd0);

      // T4: READ_PINMAP, only two of four bytes returned, timeout 64
      base = tx_n;
      accept(3'd2, 32'h0);
      wait_tx_idle("t4_txidle", base + 1);
      check("t4_txb0", {24'd0, tx_log[base]}, 32'h02);
      send_rx(8'hDE);
      rx_data  = 8'hAD;
      rx_ready = 1'b1;
      tick();
      rx_ready = 1'b0;
      wait_resp("t4_resp", 100, cyc);
      check("t4_latency", cyc, 32'd64);
      check("t4_err",     {31'd0, resp_err}, 32'd1);
      check("t4_data",    resp_data, 32'h0000DEAD);
      check("t4_ready",   {31'd0, cmd_ready}, 32'd1);
      tick();
      check("t4_pulse",   {31'd0, resp_valid}, 32'd0);

      // T5: reset during the 2nd byte of a WRITE_PINMAP
      base = tx_n;
      accept(3'd4, 32'h12345678);
      cyc = 0;
      while (tx_n != base + 2 && cyc < 200) begin
         tick();
         cyc++;
      end
      check("t5_reach_b1", tx_n - base, 32'd2);
      tick();
      rst = 1'b1;
      #1;
      check("t5_rst_ready",   {31'd0, cmd_ready},  32'd1);
      check("t5_rst_txstart", {31'd0, tx_start},   32'd0);
      check("t5_rst_txdata",  {24'd0, tx_data},    32'hFF);
      check("t5_rst_vld",     {31'd0, resp_valid}, 32'd0);
      check("t5_rst_data",    resp_data,           32'd0);
      check("t5_rst_err",     {31'd0, resp_err},   32'd0);
      tick();
      rst  = 1'b0;
      base = tx_n;
      rv_seen = 0;
      for (int i = 0; i < 20; i++) begin
         if (i == 4 || i == 10) begin
            rx_data  = 8'h77;
            rx_ready = 1'b1;
         end else begin
            rx_ready = 1'b0;
         end
         tick();
         if (resp_valid) rv_seen++;
      end
      rx_ready = 1'b0;
      check("t5_no_resp",  rv_seen, 32'd0);
      check("t5_no_tx",    tx_n - base, 32'd0);
      check("t5_idle_rdy", {31'd0, cmd_ready}, 32'd1);
      read_mask("t5_rm");

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
